// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// Module   : period_meter
// Brief    : Measures period and high time of an asynchronous sig_in in clk
//            cycles between consecutive rising edges, with a sticky timeout.
// Revision : 1.0 - initial release
// ============================================================================
module period_meter #(
    parameter  int MAX_PERIOD = 12000000,
    localparam int WIDTH      = $clog2(MAX_PERIOD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] c_max_period = WIDTH'(MAX_PERIOD);
    localparam logic [WIDTH-1:0] c_one        = WIDTH'(1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1;
    logic             r_s2;
    logic             r_prev;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_high_cnt;
    logic [WIDTH-1:0] w_high_cnt_nxt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] w_period_nxt;
    logic [WIDTH-1:0] r_high_time;
    logic [WIDTH-1:0] w_high_time_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
    logic             w_rise;

    // Synchronizer resets high so a level held through reset is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= sig_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_high_cnt  <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_high_cnt  <= w_high_cnt_nxt;
            r_period    <= w_period_nxt;
            r_high_time <= w_high_time_nxt;
            r_valid     <= w_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_high_cnt_nxt  = r_high_cnt;
        w_period_nxt    = r_period;
        w_high_time_nxt = r_high_time;
        w_valid_nxt     = 1'b0;
        w_timeout_nxt   = r_timeout;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt    = MEASURE;
                    w_cnt_nxt      = c_one;
                    w_high_cnt_nxt = c_one;
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    w_period_nxt    = r_cnt;
                    w_high_time_nxt = r_high_cnt;
                    w_valid_nxt     = 1'b1;
                    w_timeout_nxt   = 1'b0;
                    w_cnt_nxt       = c_one;
                    w_high_cnt_nxt  = c_one;
                end else if (r_cnt == c_max_period) begin
                    // Counter saturated without an edge: disarm instead of wrapping.
                    w_timeout_nxt  = 1'b1;
                    w_state_nxt    = IDLE;
                    w_cnt_nxt      = '0;
                    w_high_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                    if (r_s2) begin
                        w_high_cnt_nxt = r_high_cnt + c_one;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign period    = r_period;
    assign high_time = r_high_time;
    assign valid     = r_valid;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_period_meter
// Brief    : Randomized and directed bench for period_meter against an
//            edge-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_period_meter;

    localparam int MAXP  = 100;
    localparam int W     = $clog2(MAXP + 1);
    localparam int DEPTH = 32768;

    logic         clk = 1'b0;
    logic         rst;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;

    period_meter #(.MAX_PERIOD(MAXP)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    // Reference model: samples by edge index, scheduled output events.
    bit hist     [DEPTH];
    bit ev_valid [DEPTH];
    bit ev_to    [DEPTH];
    int ev_p     [DEPTH];
    int ev_h     [DEPTH];
    int last_rise = 0;
    bit armed     = 1'b0;
    bit prev_s    = 1'b1;
    bit m_valid   = 1'b0;
    bit m_to      = 1'b0;
    int m_period  = 0;
    int m_high    = 0;
    int valid_seen     = 0;
    int valid_expected = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t edge=%0d: got %0d expected %0d", tag, $time, edge_n, got, exp);
        end
    endtask

    // A rising edge at sample n measures n - last_rise cycles; the result is
    // visible two edges later. No rise for MAXP+1 samples means timeout.
    task automatic model_edge(input bit s);
        int n;
        int h;
        n = edge_n;
        if (n + 3 >= DEPTH) begin
            $display("FAIL model_depth: edge %0d exceeds %0d", n, DEPTH);
            $fatal(1);
        end
        hist[n] = s;
        if (armed && n == last_rise + MAXP + 1) begin
            ev_to[n+1] = 1'b1;
            armed      = 1'b0;
        end
        if (s && !prev_s) begin
            if (armed) begin
                h = 0;
                for (int k = last_rise; k < n; k++) h += int'(hist[k]);
                ev_valid[n+2] = 1'b1;
                ev_p[n+2]     = n - last_rise;
                ev_h[n+2]     = h;
            end
            armed     = 1'b1;
            last_rise = n;
        end
        prev_s  = s;
        m_valid = ev_valid[n];
        if (ev_valid[n]) begin
            m_period = ev_p[n];
            m_high   = ev_h[n];
            m_to     = 1'b0;
            valid_expected++;
        end
        if (ev_to[n]) m_to = 1'b1;
    endtask

    task automatic step(input bit s);
        sig_in = s;
        @(posedge clk);
        edge_n++;
        model_edge(s);
        #1;
        check("valid", 32'(valid), 32'(m_valid));
        check("timeout", 32'(timeout), 32'(m_to));
        check("period", 32'(period), 32'(m_period));
        check("high_time", 32'(high_time), 32'(m_high));
        if (valid === 1'b1) valid_seen++;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < hi; j++) step(1'b1);
            for (int j = 0; j < lo; j++) step(1'b0);
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset(input int cycles);
        #3;
        rst = 1'b1;
        #1;
        check("rst_period", 32'(period), 32'd0);
        check("rst_high_time", 32'(high_time), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        for (int t = edge_n + 1; t <= edge_n + cycles + 3; t++) begin
            ev_valid[t] = 1'b0;
            ev_to[t]    = 1'b0;
        end
        armed    = 1'b0;
        prev_s   = 1'b1;
        m_valid  = 1'b0;
        m_to     = 1'b0;
        m_period = 0;
        m_high   = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            edge_n++;
        end
        #3;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hi;
        int lo;
        rst    = 1'b1;
        sig_in = 1'b0;
        #2;
        check("init_period", 32'(period), 32'd0);
        check("init_valid", 32'(valid), 32'd0);
        check("init_timeout", 32'(timeout), 32'd0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;

        // 50% duty, 20-cycle period
        wave(10, 10, 8);
        // 3/7 then 8/2 duty at period 10
        wave(3, 7, 5);
        wave(8, 2, 5);
        // idle after a rise until timeout, then restart
        for (int j = 0; j < 10; j++) step(1'b1);
        for (int j = 0; j < 140; j++) step(1'b0);
        check("timeout_idle", 32'(timeout), 32'd1);
        wave(10, 10, 4);
        check("timeout_cleared", 32'(timeout), 32'd0);
        // boundary: period exactly MAXP, then MAXP+1
        wave(50, 50, 3);
        wave(51, 50, 3);
        // asynchronous reset mid-period
        wave(10, 10, 3);
        for (int j = 0; j < 5; j++) step(1'b1);
        do_reset(2);
        wave(10, 10, 4);
        // sig_in held high across reset release
        for (int j = 0; j < 4; j++) step(1'b1);
        do_reset(2);
        for (int j = 0; j < 5; j++) step(1'b1);
        for (int j = 0; j < 10; j++) step(1'b0);
        wave(10, 10, 4);
        // random duty and period, occasionally beyond the timeout
        for (int i = 0; i < 150; i++) begin
            hi = int'($urandom_range(1, 60));
            if ($urandom_range(0, 9) == 0) lo = int'($urandom_range(90, 130));
            else lo = int'($urandom_range(1, 60));
            wave(hi, lo, 1);
        end
        for (int j = 0; j < 5; j++) step(1'b0);
        check("valid_count", 32'(valid_seen), 32'(valid_expected));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
